// File: rtl/cr_kme_kop_kdf_stream_fifo_pkg.sv
// Shared constants for the KOP KDF byte-stream staging buffer.
package cr_kme_kop_kdf_stream_fifo_pkg;

  localparam int unsigned KDF_STREAM_IN_BYTES  = 32;
  localparam int unsigned KDF_STREAM_OUT_BYTES = 16;
  localparam int unsigned KDF_STREAM_BUF_BYTES = 48;

  // Width of a field able to hold the values 0..n.
  function automatic int unsigned nb_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned KDF_STREAM_IN_NB_W  = nb_width(KDF_STREAM_IN_BYTES);
  localparam int unsigned KDF_STREAM_OUT_NB_W = nb_width(KDF_STREAM_OUT_BYTES);
  localparam int unsigned KDF_STREAM_CNT_W    = nb_width(KDF_STREAM_BUF_BYTES);

endpackage

// File: rtl/cr_kme_kop_kdf_stream_fifo_if.sv
// Command-in / window-out handshake bundle of the KDF stream buffer.
interface cr_kme_kop_kdf_stream_fifo_if
  import cr_kme_kop_kdf_stream_fifo_pkg::*;
#(
  parameter int unsigned IN_BYTES  = KDF_STREAM_IN_BYTES,
  parameter int unsigned OUT_BYTES = KDF_STREAM_OUT_BYTES
);
  localparam int unsigned IN_NB_W  = nb_width(IN_BYTES);
  localparam int unsigned OUT_NB_W = nb_width(OUT_BYTES);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [IN_BYTES*8-1:0]   cmd_data;
  logic [IN_NB_W-1:0]      cmd_num_bytes;
  logic                    cmd_last;
  logic                    pipe_valid;
  logic [OUT_BYTES*8-1:0]  pipe_data;
  logic [OUT_NB_W-1:0]     pipe_num_bytes;
  logic                    pipe_last;
  logic                    pipe_ack;
  logic [OUT_NB_W-1:0]     pipe_ack_num_bytes;

  modport master (
    output cmd_valid, cmd_data, cmd_num_bytes, cmd_last, pipe_ack, pipe_ack_num_bytes,
    input  cmd_ready, pipe_valid, pipe_data, pipe_num_bytes, pipe_last
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_num_bytes, cmd_last, pipe_ack, pipe_ack_num_bytes,
    output cmd_ready, pipe_valid, pipe_data, pipe_num_bytes, pipe_last
  );
endinterface

// File: rtl/cr_kme_kop_kdf_stream_fifo_byte_shift_merge.sv
// Combinational merge: buffer shifted left by i_shift bytes, OR the first
// i_data_bytes bytes of i_data placed at byte offset i_offset.
module cr_kme_byte_shift_merge
  import cr_kme_kop_kdf_stream_fifo_pkg::*;
#(
  parameter int unsigned BUF_BYTES = KDF_STREAM_BUF_BYTES,
  parameter int unsigned IN_BYTES  = KDF_STREAM_IN_BYTES,
  parameter int unsigned CNT_W     = nb_width(BUF_BYTES),
  parameter int unsigned NB_W      = nb_width(IN_BYTES)
) (
  input  logic [BUF_BYTES*8-1:0] i_buf,
  input  logic [CNT_W-1:0]       i_shift,
  input  logic [IN_BYTES*8-1:0]  i_data,
  input  logic [NB_W-1:0]        i_data_bytes,
  input  logic [CNT_W-1:0]       i_offset,
  output logic [BUF_BYTES*8-1:0] o_buf
);
  localparam logic [IN_BYTES*8-1:0] ONES = '1;

  logic [IN_BYTES*8-1:0]  w_keep;
  logic [BUF_BYTES*8-1:0] w_ext;

  always_comb begin
    w_keep = ~(ONES >> {i_data_bytes, 3'b000});
    w_ext  = '0;
    w_ext[BUF_BYTES*8-1 -: IN_BYTES*8] = i_data & w_keep;
    o_buf  = (i_buf << {i_shift, 3'b000}) | (w_ext >> {i_offset, 3'b000});
  end
endmodule

// File: rtl/cr_kme_kop_kdf_stream_fifo.sv
// Byte-stream staging buffer: packs message-delimited command words into a
// left-aligned byte buffer and exposes an OUT_BYTES window to the hash engine.
module cr_kme_kop_kdf_stream_fifo
  import cr_kme_kop_kdf_stream_fifo_pkg::*;
#(
  parameter int unsigned IN_BYTES  = KDF_STREAM_IN_BYTES,
  parameter int unsigned OUT_BYTES = KDF_STREAM_OUT_BYTES,
  parameter int unsigned BUF_BYTES = KDF_STREAM_BUF_BYTES,
  localparam int unsigned CNT_W    = nb_width(BUF_BYTES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_flush,
  cr_kme_kop_kdf_stream_fifo_if.slave   kdf_if,
  output logic [CNT_W-1:0]              o_buf_count,
  output logic                          o_cmd_err,
  output logic                          o_ack_err
);
  localparam int unsigned IN_W  = nb_width(IN_BYTES);
  localparam int unsigned OUT_W = nb_width(OUT_BYTES);

  if (BUF_BYTES < IN_BYTES + OUT_BYTES - 1) begin : g_param_check
    $error("BUF_BYTES must be >= IN_BYTES + OUT_BYTES - 1");
  end

  logic [BUF_BYTES*8-1:0] r_buf;
  logic [BUF_BYTES*8-1:0] w_buf_nxt;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_nxt;
  logic [CNT_W-1:0]       w_shift;
  logic [CNT_W-1:0]       w_offset;
  logic                   r_last_pend;
  logic                   r_out_en;
  logic                   r_cmd_err;
  logic                   r_ack_err;
  logic                   w_cmd_ready;
  logic                   w_pipe_valid;
  logic                   w_accept;
  logic                   w_cmd_legal;
  logic                   w_ack_ok;
  logic [OUT_W-1:0]       w_pipe_nb;
  logic [IN_W-1:0]        w_merge_nb;

  // r_out_en keeps cmd_ready low while reset is held.
  always_comb begin
    w_cmd_ready  = r_out_en && !r_last_pend &&
                   ((CNT_W'(BUF_BYTES) - r_count) >= CNT_W'(IN_BYTES));
    w_pipe_valid = (r_count >= CNT_W'(OUT_BYTES)) || (r_last_pend && (r_count != '0));
    w_pipe_nb    = (r_count >= CNT_W'(OUT_BYTES)) ? OUT_W'(OUT_BYTES) : OUT_W'(r_count);
    w_accept     = kdf_if.cmd_valid && w_cmd_ready;
    w_cmd_legal  = (kdf_if.cmd_num_bytes != '0) &&
                   (kdf_if.cmd_num_bytes <= IN_W'(IN_BYTES));
    w_ack_ok     = kdf_if.pipe_ack && w_pipe_valid &&
                   (kdf_if.pipe_ack_num_bytes != '0) &&
                   (kdf_if.pipe_ack_num_bytes <= w_pipe_nb);
    w_shift      = w_ack_ok ? CNT_W'(kdf_if.pipe_ack_num_bytes) : '0;
    w_offset     = r_count - w_shift;
    w_merge_nb   = (w_accept && w_cmd_legal) ? kdf_if.cmd_num_bytes : '0;
    w_count_nxt  = w_offset + CNT_W'(w_merge_nb);
  end

  cr_kme_byte_shift_merge #(
    .BUF_BYTES (BUF_BYTES),
    .IN_BYTES  (IN_BYTES),
    .CNT_W     (CNT_W),
    .NB_W      (IN_W)
  ) u_merge (
    .i_buf        (r_buf),
    .i_shift      (w_shift),
    .i_data       (kdf_if.cmd_data),
    .i_data_bytes (w_merge_nb),
    .i_offset     (w_offset),
    .o_buf        (w_buf_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_count     <= '0;
      r_last_pend <= 1'b0;
      r_out_en    <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_ack_err   <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      if (i_flush) begin
        r_buf       <= '0;
        r_count     <= '0;
        r_last_pend <= 1'b0;
        r_cmd_err   <= 1'b0;
        r_ack_err   <= 1'b0;
      end else begin
        r_buf     <= w_buf_nxt;
        r_count   <= w_count_nxt;
        r_cmd_err <= w_accept && !w_cmd_legal;
        r_ack_err <= kdf_if.pipe_ack && !w_ack_ok;
        if (w_accept && w_cmd_legal) begin
          r_last_pend <= kdf_if.cmd_last;
        end else if (w_ack_ok && (w_offset == '0)) begin
          r_last_pend <= 1'b0;
        end
      end
    end
  end

  assign kdf_if.cmd_ready      = w_cmd_ready;
  assign kdf_if.pipe_valid     = w_pipe_valid;
  assign kdf_if.pipe_data      = r_buf[BUF_BYTES*8-1 -: OUT_BYTES*8];
  assign kdf_if.pipe_num_bytes = w_pipe_nb;
  assign kdf_if.pipe_last      = r_last_pend && (r_count <= CNT_W'(OUT_BYTES));
  assign o_buf_count           = r_count;
  assign o_cmd_err             = r_cmd_err;
  assign o_ack_err             = r_ack_err;
endmodule

// File: tb/tb_cr_kme_kop_kdf_stream_fifo.sv
// Scoreboard bench for cr_kme_kop_kdf_stream_fifo against a byte-queue model.
module tb_cr_kme_kop_kdf_stream_fifo;
  import cr_kme_kop_kdf_stream_fifo_pkg::*;

  localparam int unsigned IB = KDF_STREAM_IN_BYTES;
  localparam int unsigned OB = KDF_STREAM_OUT_BYTES;
  localparam int unsigned BB = KDF_STREAM_BUF_BYTES;
  localparam int unsigned DW = IB * 8;

  typedef struct {
    int           cnt;
    bit           valid;
    int           nb;
    logic [127:0] data;
    bit           last;
    bit           ready;
    bit           cerr;
    bit           aerr;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic [KDF_STREAM_CNT_W-1:0] buf_count;
  logic cmd_err;
  logic ack_err;

  cr_kme_kop_kdf_stream_fifo_if #(.IN_BYTES(IB), .OUT_BYTES(OB)) kif ();

  cr_kme_kop_kdf_stream_fifo #(
    .IN_BYTES  (IB),
    .OUT_BYTES (OB),
    .BUF_BYTES (BB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (flush),
    .kdf_if      (kif),
    .o_buf_count (buf_count),
    .o_cmd_err   (cmd_err),
    .o_ack_err   (ack_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned mq[$];
  bit   m_last = 1'b0;
  bit   m_en   = 1'b0;
  exp_t sb[$];

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int m_wn();
    return (mq.size() < OB) ? mq.size() : OB;
  endfunction

  function automatic bit m_valid();
    return (mq.size() >= OB) || (m_last && mq.size() > 0);
  endfunction

  function automatic bit m_ready();
    return m_en && !m_last && ((BB - mq.size()) >= IB);
  endfunction

  function automatic exp_t snap(input bit cerr, input bit aerr);
    exp_t e;
    e.cnt   = mq.size();
    e.valid = m_valid();
    e.nb    = m_wn();
    e.data  = '0;
    for (int i = 0; i < m_wn(); i++) e.data[127-8*i -: 8] = mq[i];
    e.last  = m_last && (mq.size() <= OB);
    e.ready = m_ready();
    e.cerr  = cerr;
    e.aerr  = aerr;
    return e;
  endfunction

  function automatic logic [DW-1:0] mk_seq(input int start);
    logic [DW-1:0] d;
    for (int i = 0; i < IB; i++) d[DW-1-8*i -: 8] = 8'(start + i);
    return d;
  endfunction

  // Monitor: compares the registered outputs against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("buf_count", buf_count, e.cnt);
      chk("cmd_ready", kif.cmd_ready, e.ready);
      chk("pipe_valid", kif.pipe_valid, e.valid);
      chk("pipe_num_bytes", kif.pipe_num_bytes, e.nb);
      chk("pipe_last", kif.pipe_last, e.last);
      chk("cmd_err", cmd_err, e.cerr);
      chk("ack_err", ack_err, e.aerr);
      if (kif.pipe_valid) chk("pipe_data", kif.pipe_data, e.data);
    end
  end

  // One clock of stimulus; starts just after a falling edge and ends on one.
  task automatic step(input bit v, input logic [DW-1:0] d, input int nb, input bit lst,
                      input bit ack, input int an, input bit fl);
    bit acc, legal, ackok, cerr, aerr;
    kif.cmd_valid          = v;
    kif.cmd_data           = d;
    kif.cmd_num_bytes      = KDF_STREAM_IN_NB_W'(nb);
    kif.cmd_last           = lst;
    kif.pipe_ack           = ack;
    kif.pipe_ack_num_bytes = KDF_STREAM_OUT_NB_W'(an);
    flush                  = fl;
    acc   = v && m_ready();
    legal = (nb >= 1) && (nb <= IB);
    ackok = ack && m_valid() && (an >= 1) && (an <= m_wn());
    cerr  = acc && !legal;
    aerr  = ack && !ackok;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      m_last = 1'b0;
      cerr   = 1'b0;
      aerr   = 1'b0;
    end else begin
      if (ackok) begin
        repeat (an) void'(mq.pop_front());
        if (mq.size() == 0) m_last = 1'b0;
      end
      if (acc && legal) begin
        for (int i = 0; i < nb; i++) mq.push_back(d[DW-1-8*i -: 8]);
        m_last = lst;
      end
    end
    m_en = 1'b1;
    sb.push_back(snap(cerr, aerr));
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    kif.cmd_valid = 1'b0;
    kif.pipe_ack  = 1'b0;
    flush         = 1'b0;
    #1;
    chk("async_rst_count", buf_count, 0);
    chk("async_rst_valid", kif.pipe_valid, 0);
    chk("async_rst_ready", kif.cmd_ready, 0);
    mq.delete();
    m_last = 1'b0;
    m_en   = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 sb.push_back(snap(1'b0, 1'b0));
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int sent, r, nb, an;
    logic [DW-1:0] rd;
    rst_n                  = 1'b1;
    flush                  = 1'b0;
    kif.cmd_valid          = 1'b0;
    kif.cmd_data           = '0;
    kif.cmd_num_bytes      = '0;
    kif.cmd_last           = 1'b0;
    kif.pipe_ack           = 1'b0;
    kif.pipe_ack_num_bytes = '0;

    do_reset();
    idle();

    // Single full word with last, drained in two windows.
    step(1'b1, mk_seq(0), 32, 1'b1, 1'b0, 0, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 16, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 16, 1'b0);
    idle();

    // Short words packed across word boundaries.
    step(1'b1, mk_seq(8'h40), 5, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, mk_seq(8'h50), 7, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, mk_seq(8'h60), 9, 1'b1, 1'b0, 0, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 16, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 5, 1'b0);
    idle();

    // Streaming full words with concurrent acks.
    sent = 0;
    for (int c = 0; c < 200 && (sent < 8 || mq.size() > 0); c++) begin
      bit rdy;
      rdy = m_ready();
      step(sent < 8, mk_seq(sent * 32), 32, 1'b0, m_valid(), m_wn(), 1'b0);
      if (sent < 8 && rdy) sent++;
    end
    idle();

    // Protocol errors.
    step(1'b1, mk_seq(1), 0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, mk_seq(1), 33, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 1, 1'b0);
    step(1'b1, mk_seq(8'h80), 16, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 0, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 17, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 16, 1'b0);
    idle();

    // Flush wins over a same-cycle ack.
    step(1'b1, mk_seq(8'hA0), 20, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, mk_seq(8'hC0), 8, 1'b0, 1'b1, 16, 1'b1);
    idle();

    // Asynchronous reset mid-stream.
    step(1'b1, mk_seq(8'h10), 32, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, '0, 0, 1'b0, 1'b1, 16, 1'b0);
    do_reset();
    idle();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      for (int w = 0; w < IB / 4; w++) rd[32*w +: 32] = $urandom;
      r  = $urandom % 20;
      nb = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(33, 63)) : int'($urandom_range(1, IB));
      if (m_valid()) begin
        r  = $urandom % 10;
        an = (r == 0) ? 0 : (r == 1) ? m_wn() + 1 : int'($urandom_range(1, m_wn()));
        step(($urandom % 3) != 0, rd, nb, ($urandom % 6) == 0, ($urandom % 3) != 0, an,
             ($urandom % 100) == 0);
      end else begin
        step(($urandom % 3) != 0, rd, nb, ($urandom % 6) == 0, ($urandom % 20) == 0,
             int'($urandom_range(0, OB)), ($urandom % 100) == 0);
      end
    end
    idle();

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
